// File: rtl/vga_pkg.sv
// vga_pkg: shared timing constants for the 1280x1024@60 raster path
// (108 MHz pixel clock) and the coordinate width used by every block
// that produces or consumes pixel coordinates.
package vga_pkg;

  // Width of every coordinate bus (pixel column, line, shape anchor).
  localparam int COORD_W = 11;

  // Horizontal timing, in pixels.
  localparam int H_VIS    = 1280;
  localparam int H_FP_D   = 48;
  localparam int H_SYNC_D = 112;
  localparam int H_BP_D   = 248;
  localparam int H_TOTAL  = H_VIS + H_FP_D + H_SYNC_D + H_BP_D;

  // Vertical timing, in lines.
  localparam int V_VIS    = 1024;
  localparam int V_FP_D   = 1;
  localparam int V_SYNC_D = 3;
  localparam int V_BP_D   = 38;
  localparam int V_TOTAL  = V_VIS + V_FP_D + V_SYNC_D + V_BP_D;

endpackage

// File: rtl/passo_modulare.sv
// passo_modulare: combinational wrap-adder for one axis of the shape anchor.
// Adds or subtracts a 4-bit step to a position and wraps the result back
// into [0, modulus). Works on 12 bits internally so pos+modulus cannot
// overflow, then truncates to the coordinate width.
//   i_pos     current position, always < i_modulus
//   i_step    step magnitude
//   i_dir     0 = add, 1 = subtract
//   i_modulus wrap modulus (H or V)
//   o_next    wrapped next position
module passo_modulare
  import vga_pkg::*;
(
  input  logic [COORD_W-1:0] i_pos,
  input  logic [3:0]         i_step,
  input  logic               i_dir,
  input  logic [COORD_W:0]   i_modulus,
  output logic [COORD_W-1:0] o_next
);

  logic [COORD_W:0] w_pos;
  logic [COORD_W:0] w_step;
  logic [COORD_W:0] w_sum;
  logic [COORD_W:0] w_wrapped;

  assign w_pos  = {1'b0, i_pos};
  assign w_step = {{(COORD_W-3){1'b0}}, i_step};

  // Only one correction is ever needed: position < modulus and step < 16
  // never exceeds a single modulus in either direction.
  always_comb begin
    w_sum     = w_pos + w_step;
    w_wrapped = w_pos;
    if (!i_dir) begin
      w_wrapped = (w_sum >= i_modulus) ? (w_sum - i_modulus) : w_sum;
    end else if (w_pos < w_step) begin
      w_wrapped = w_pos + i_modulus - w_step;
    end else begin
      w_wrapped = w_pos - w_step;
    end
  end

  assign o_next = w_wrapped[COORD_W-1:0];

endmodule

// File: rtl/vga_scansione.sv
// vga_scansione: raster scan generator. Produces the current pixel
// coordinates for the shape hit-test blocks, sync and active-video flags,
// a one-cycle frame tick at the start of vertical blanking, and a shape
// anchor that steps once per frame with modular wrap.
//   CLK, RST_N        pixel clock, async active-low reset
//   EN                pixel clock enable, freezes all state when low
//   STEP_X/Y, DIR_X/Y per-frame anchor step and direction
//   MOVE              apply the step at the frame tick
//   X_/Y_CONTROLLO    current column / line
//   ATTIVO            inside the visible area
//   HSYNC, VSYNC      syncs, active level SYNC_POL
//   FRAME_TICK        pulse when the coordinates become (0, V)
//   X_POS, Y_POS      shape anchor, always inside H x V
module vga_scansione
  import vga_pkg::*;
#(
  parameter int   H        = H_VIS,
  parameter int   V        = V_VIS,
  parameter int   H_FP     = H_FP_D,
  parameter int   H_SYNC   = H_SYNC_D,
  parameter int   H_BP     = H_BP_D,
  parameter int   V_FP     = V_FP_D,
  parameter int   V_SYNC   = V_SYNC_D,
  parameter int   V_BP     = V_BP_D,
  parameter logic SYNC_POL = 1'b1,
  parameter int   X_INIT   = 0,
  parameter int   Y_INIT   = 0
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               EN,
  input  logic [3:0]         STEP_X,
  input  logic [3:0]         STEP_Y,
  input  logic               DIR_X,
  input  logic               DIR_Y,
  input  logic               MOVE,
  output logic [COORD_W-1:0] X_CONTROLLO,
  output logic [COORD_W-1:0] Y_CONTROLLO,
  output logic               ATTIVO,
  output logic               HSYNC,
  output logic               VSYNC,
  output logic               FRAME_TICK,
  output logic [COORD_W-1:0] X_POS,
  output logic [COORD_W-1:0] Y_POS
);

  localparam int H_TOT = H + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V + V_FP + V_SYNC + V_BP;

  localparam logic [COORD_W-1:0] X_LAST   = COORD_W'(H_TOT - 1);
  localparam logic [COORD_W-1:0] Y_LAST   = COORD_W'(V_TOT - 1);
  localparam logic [COORD_W-1:0] X_VIS    = COORD_W'(H);
  localparam logic [COORD_W-1:0] Y_VIS    = COORD_W'(V);
  localparam logic [COORD_W-1:0] HS_FIRST = COORD_W'(H + H_FP);
  localparam logic [COORD_W-1:0] HS_LAST  = COORD_W'(H + H_FP + H_SYNC - 1);
  localparam logic [COORD_W-1:0] VS_FIRST = COORD_W'(V + V_FP);
  localparam logic [COORD_W-1:0] VS_LAST  = COORD_W'(V + V_FP + V_SYNC - 1);
  localparam logic [COORD_W:0]   H_MOD    = (COORD_W+1)'(H);
  localparam logic [COORD_W:0]   V_MOD    = (COORD_W+1)'(V);

  logic [COORD_W-1:0] r_x, r_y, r_xPos, r_yPos;
  logic               r_attivo, r_hsync, r_vsync, r_tick;

  logic [COORD_W-1:0] w_xNext, w_yNext, w_xPosNext, w_yPosNext;
  logic               w_attivo, w_hsync, w_vsync, w_tick;

  always_comb begin
    w_xNext = r_x + COORD_W'(1);
    w_yNext = r_y;
    if (r_x == X_LAST) begin
      w_xNext = '0;
      w_yNext = (r_y == Y_LAST) ? '0 : (r_y + COORD_W'(1));
    end
  end

  // Flags are decoded from the next coordinates so that, once registered,
  // they line up with the coordinates they describe.
  assign w_attivo = (w_xNext < X_VIS) && (w_yNext < Y_VIS);
  assign w_hsync  = ((w_xNext >= HS_FIRST) && (w_xNext <= HS_LAST)) ? SYNC_POL : ~SYNC_POL;
  assign w_vsync  = ((w_yNext >= VS_FIRST) && (w_yNext <= VS_LAST)) ? SYNC_POL : ~SYNC_POL;
  assign w_tick   = (w_xNext == '0) && (w_yNext == Y_VIS);

  passo_modulare u_passoX (
    .i_pos     (r_xPos),
    .i_step    (STEP_X),
    .i_dir     (DIR_X),
    .i_modulus (H_MOD),
    .o_next    (w_xPosNext)
  );

  passo_modulare u_passoY (
    .i_pos     (r_yPos),
    .i_step    (STEP_Y),
    .i_dir     (DIR_Y),
    .i_modulus (V_MOD),
    .o_next    (w_yPosNext)
  );

  // The anchor only moves on the edge that raises FRAME_TICK, i.e. at the
  // start of vertical blanking, so it never changes during visible video.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_x      <= '0;
      r_y      <= '0;
      r_attivo <= 1'b0;
      r_hsync  <= ~SYNC_POL;
      r_vsync  <= ~SYNC_POL;
      r_tick   <= 1'b0;
      r_xPos   <= COORD_W'(X_INIT);
      r_yPos   <= COORD_W'(Y_INIT);
    end else if (EN) begin
      r_x      <= w_xNext;
      r_y      <= w_yNext;
      r_attivo <= w_attivo;
      r_hsync  <= w_hsync;
      r_vsync  <= w_vsync;
      r_tick   <= w_tick;
      if (w_tick && MOVE) begin
        r_xPos <= w_xPosNext;
        r_yPos <= w_yPosNext;
      end
    end
  end

  assign X_CONTROLLO = r_x;
  assign Y_CONTROLLO = r_y;
  assign ATTIVO      = r_attivo;
  assign HSYNC       = r_hsync;
  assign VSYNC       = r_vsync;
  assign FRAME_TICK  = r_tick;
  assign X_POS       = r_xPos;
  assign Y_POS       = r_yPos;

endmodule
